// File: rtl/max_scan_engine.sv
// rtl/max_scan_engine.sv - memory-master scan for the signed maximum and its index
// Reads len words from baseAddr, then writes the max to MAX_ADDR and its index to IDX_ADDR.
module max_scan_engine #(
   parameter logic [31:0] MAX_ADDR = 32'd2000,
   parameter logic [31:0] IDX_ADDR = 32'd2004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] baseAddr,
   input  logic [15:0] len,
   input  logic [31:0] readData,
   output logic [31:0] address,
   output logic [31:0] writeData,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {IDLE, READ, WRITE_MAX, WRITE_IDX, DONE} state_t;

   state_t      state;
   logic [15:0] len_r;
   logic [15:0] i;
   logic [31:0] max_reg;
   logic [15:0] idx_reg;

   logic        take_new;
   logic [31:0] next_max;
   logic [15:0] next_idx;
   logic        last_elem;

   // Strict greater-than keeps the earlier index on ties; element 0 always seeds the max.
   always_comb begin
      take_new  = (i == 16'd0) || ($signed(readData) > $signed(max_reg));
      next_max  = take_new ? readData : max_reg;
      next_idx  = take_new ? i : idx_reg;
      last_elem = (i == (len_r - 16'd1));
   end

   // Outputs are registered one cycle ahead so each state presents its own strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         len_r     <= '0;
         i         <= '0;
         max_reg   <= 32'h8000_0000;
         idx_reg   <= '0;
         address   <= '0;
         writeData <= '0;
         MemRead   <= 1'b0;
         MemWrite  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  len_r   <= len;
                  i       <= '0;
                  max_reg <= 32'h8000_0000;
                  idx_reg <= '0;
                  busy    <= 1'b1;
                  if (len == 16'd0) begin
                     state     <= WRITE_MAX;
                     MemWrite  <= 1'b1;
                     address   <= MAX_ADDR;
                     writeData <= 32'h8000_0000;
                  end else begin
                     state   <= READ;
                     MemRead <= 1'b1;
                     address <= baseAddr;
                  end
               end
            end
            READ: begin
               max_reg <= next_max;
               idx_reg <= next_idx;
               if (last_elem) begin
                  state     <= WRITE_MAX;
                  MemRead   <= 1'b0;
                  MemWrite  <= 1'b1;
                  address   <= MAX_ADDR;
                  writeData <= next_max;
               end else begin
                  i       <= i + 16'd1;
                  address <= address + 32'd4;
               end
            end
            WRITE_MAX: begin
               state     <= WRITE_IDX;
               address   <= IDX_ADDR;
               writeData <= {16'd0, idx_reg};
            end
            WRITE_IDX: begin
               state     <= DONE;
               MemWrite  <= 1'b0;
               address   <= '0;
               writeData <= '0;
               busy      <= 1'b0;
               done      <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               address   <= '0;
               writeData <= '0;
               MemRead   <= 1'b0;
               MemWrite  <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_max_scan_engine.sv
// tb/tb_max_scan_engine.sv - directed-vector bench for max_scan_engine
module tb_max_scan_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] baseAddr = '0;
   logic [15:0] len = '0;
   logic [31:0] readData;
   logic [31:0] address, writeData;
   logic        MemRead, MemWrite, busy, done;

   int vectors = 0;
   int miscompares = 0;
   int wr_count = 0;
   int rd_count = 0;
   int overlap_cnt = 0;
   logic [31:0] rd_log[$];
   logic [31:0] mem [0:1023];

   max_scan_engine dut (
      .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr), .len(len),
      .readData(readData), .address(address), .writeData(writeData),
      .MemRead(MemRead), .MemWrite(MemWrite), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always_comb readData = mem[address[11:2]];

   always @(posedge clk) begin
      if (MemRead && MemWrite) overlap_cnt++;
      if (MemWrite) begin
         mem[address[11:2]] <= writeData;
         wr_count++;
      end
      if (MemRead) begin
         rd_count++;
         rd_log.push_back(address);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_scan(input string tag, input logic [31:0] base, input logic [15:0] n,
                           input logic hold, input logic [31:0] exp_max, input logic [31:0] exp_idx);
      int  cycles;
      bit  seen;
      wr_count = 0;
      rd_count = 0;
      rd_log.delete();
      mem[500] = 32'h5A5A_5A5A;
      mem[501] = 32'hA5A5_A5A5;
      @(negedge clk);
      start = 1'b1;
      baseAddr = base;
      len = n;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      cycles = 0;
      seen = 1'b0;
      while (!seen && cycles < 100) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) check({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
         if (hold) begin
            baseAddr = $urandom;
            len = 16'($urandom_range(1, 20));
         end
         if (done) begin
            seen = 1'b1;
            start = 1'b0;
            check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
         end
      end
      check({tag, "_done_latency"}, cycles, 32'(n) + 32'd3);
      repeat (4) @(negedge clk);
      check({tag, "_max"}, mem[500], exp_max);
      check({tag, "_idx"}, mem[501], exp_idx);
      check({tag, "_writes"}, wr_count, 32'd2);
      check({tag, "_reads"}, rd_count, 32'(n));
   endtask

   initial begin
      for (int k = 0; k < 1024; k++) mem[k] = '0;

      repeat (3) @(negedge clk);
      check("reset_outputs", {address, writeData, 26'd0, MemRead, MemWrite, busy, done, 2'b00}, '0);
      rst = 1'b0;

      // basic scan, tie at 9 keeps index 1
      mem[0] = 32'd3; mem[1] = 32'd9; mem[2] = -32'sd2; mem[3] = 32'd9; mem[4] = 32'd4;
      run_scan("basic", 32'd0, 16'd5, 1'b0, 32'd9, 32'd1);

      mem[10] = -32'sd5; mem[11] = -32'sd1; mem[12] = -32'sd7;
      run_scan("neg", 32'd40, 16'd3, 1'b0, 32'hFFFF_FFFF, 32'd1);

      mem[20] = 32'h7FFF_FFFF; mem[21] = 32'h8000_0000;
      run_scan("extremes", 32'd80, 16'd2, 1'b0, 32'h7FFF_FFFF, 32'd0);

      mem[30] = 32'h8000_0000; mem[31] = 32'h8000_0000;
      run_scan("min_tie", 32'd120, 16'd2, 1'b0, 32'h8000_0000, 32'd0);

      run_scan("len0", 32'd0, 16'd0, 1'b0, 32'h8000_0000, 32'd0);

      mem[25] = 32'd42;
      run_scan("len1", 32'd100, 16'd1, 1'b0, 32'd42, 32'd0);

      mem[1023] = 32'd5; mem[0] = 32'd11;
      run_scan("wrap", 32'hFFFF_FFFC, 16'd2, 1'b0, 32'd11, 32'd1);
      check("wrap_addr0", rd_log.size() > 0 ? rd_log[0] : 32'hX, 32'hFFFF_FFFC);
      check("wrap_addr1", rd_log.size() > 1 ? rd_log[1] : 32'hX, 32'h0000_0000);

      mem[50] = 32'd1; mem[51] = -32'sd3; mem[52] = 32'd2;
      run_scan("held_start", 32'd200, 16'd3, 1'b1, 32'd2, 32'd2);
      check("held_read_addr2", rd_log.size() > 2 ? rd_log[2] : 32'hX, 32'd208);

      // reset while reading element 2 of a 6-word scan
      for (int k = 0; k < 6; k++) mem[100 + k] = 32'(k * 3);
      mem[500] = 32'hDEAD_0000;
      mem[501] = 32'hDEAD_0001;
      wr_count = 0;
      @(negedge clk);
      start = 1'b1; baseAddr = 32'd400; len = 16'd6;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_elem2_addr", address, 32'd408);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_outputs", {address, writeData, 26'd0, MemRead, MemWrite, busy, done, 2'b00}, '0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_no_writes", wr_count, 32'd0);
      check("rst_max_untouched", mem[500], 32'hDEAD_0000);
      check("rst_idx_untouched", mem[501], 32'hDEAD_0001);
      run_scan("after_rst", 32'd400, 16'd6, 1'b0, 32'd15, 32'd5);

      check("no_rd_wr_overlap", overlap_cnt, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/max_scan_engine.md
# max_scan_engine

Bus-initiator block that drives the byte-addressed, little-endian 32-bit data-memory port from the requesting side. On `start` it reads `len` consecutive words from `baseAddr`, tracks the signed maximum and its element index, then writes the maximum to byte address 2000 and the index to byte address 2004, where the result-watch outputs of the data memory pick them up. It sits beside the datapath as a memory master; the top level gives it the memory port while `busy` is high.

## Interface
Parameters:
- `MAX_ADDR`, 32'd2000, byte address written with the maximum value.
- `IDX_ADDR`, 32'd2004, byte address written with the maximum's element index.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `baseAddr`  in  32  byte address of element 0; latched when `start` is accepted.
- `len`  in  16  number of words; latched when `start` is accepted.
- `readData`  in  32  word returned by memory; combinational from `address`/`MemRead`.
- `address`  out  32  byte address to memory.
- `writeData`  out  32  word to memory.
- `MemRead`  out  1  read strobe.
- `MemWrite`  out  1  write strobe; memory commits on the next rising edge.
- `busy`  out  1  high from the cycle after `start` is accepted through the WRITE_IDX cycle.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, READ, WRITE_MAX, WRITE_IDX, DONE.
- IDLE: all strobes low, `address` = 0, `writeData` = 0. If `start` = 1, latch `baseAddr` and `len`, clear counter `i` = 0, set `maxReg` = 32'h8000_0000 and `idxReg` = 0. Go to READ, or to WRITE_MAX if `len` = 0.
- READ: `MemRead` = 1, `address` = base + 4*i, wrapping mod 2^32. On the edge, if `i` = 0 or `$signed(readData) > $signed(maxReg)`, load `maxReg` = readData and `idxReg` = i. Ties keep the earlier index. Increment `i`; when `i` = len-1, go to WRITE_MAX.
- WRITE_MAX: `MemWrite` = 1, `address` = MAX_ADDR, `writeData` = maxReg. Go to WRITE_IDX.
- WRITE_IDX: `MemWrite` = 1, `address` = IDX_ADDR, `writeData` = {16'd0, idxReg}. Go to DONE.
- DONE: `done` = 1, strobes low, `busy` = 0. Go to IDLE.
- `MemRead` and `MemWrite` are never high in the same cycle.
- `start` outside IDLE is ignored; no queuing.
- Changes to `baseAddr`/`len` after acceptance have no effect.
- Empty scan (`len` = 0): writes max = 32'h8000_0000 and index = 0.
- Index is the element number (0..len-1), not a byte address.

## Timing
- Reset: the state returns to IDLE on the first edge with `rst` high. All outputs read 0 from that edge: `address`, `writeData`, `MemRead`, `MemWrite`, `busy`, `done`.
- Reset mid-scan or mid-write: no further strobes after the reset edge; a write whose strobe was high on the reset edge is not guaranteed.
- `start` accepted at edge T0: the READ for element k is presented during cycle T0+1+k.
- WRITE_MAX runs during T0+1+len and WRITE_IDX during T0+2+len. `done` is high during T0+3+len.
- Latency from `start` to `done` is len+3 cycles; with `len` = 0 it is 3 cycles.
- A new `start` can be accepted in the IDLE cycle after DONE. Back-to-back throughput is len+4 cycles per scan.
- Outputs are decoded from registered state and counter only, so there are no combinational paths from `start`, `readData` or `len` to any output.

## Test plan
- Basic scan: base=0, len=5, words {3, 9, -2, 9, 4} -> mem[2000..2003]=9, mem[2004..2007]=1. `done` pulses at start+8.
- Signed compare: words {-5, -1, -7} -> max=32'hFFFF_FFFF, index=1; {0x7FFF_FFFF, 0x8000_0000} -> max=0x7FFF_FFFF, index=0.
- Edge lengths: len=0 -> max=32'h8000_0000, index=0, `done` at start+3. len=1 with base=100 and word 42 -> max=42, index=0.
- Address wrap: base=32'hFFFF_FFFC, len=2 -> read addresses FFFF_FFFC then 0000_0000.
- Protocol: `start` held high for the whole scan with `len` and `baseAddr` changing -> exactly one scan using the latched values. Assert `MemRead & MemWrite` is never 1 and exactly 2 write cycles occur per scan.
- Reset in READ at element 2 of len=6 -> the next edge shows all outputs at 0. No write to 2000 or 2004 occurs, and a fresh `start` afterwards completes normally.
